// File: rtl/cell_test_pkg.sv
// Shared types and constants for the logic-cell test sequencer.
package cell_test_pkg;

  localparam int ERR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Gray-ordered {C,B,A} stimulus; entry 0 is the least significant slice.
  localparam logic [7:0][2:0] GRAY_VEC = {
    3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000
  };

endpackage

// File: rtl/cts_settle_timer.sv
// Down-counter that times the settle interval before each sample.
module cts_settle_timer (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != 8'd0)) begin
      count <= count - 8'd1;
    end else begin
      count <= count;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/cell_test_seq.sv
// Walks a 3-input cell through all Gray-ordered vectors and scores its outputs.
module cell_test_seq
  import cell_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  logic             Abort,
  input  logic [7:0]       TruthTable,
  input  logic             Y,
  input  logic             Yld0,
  input  logic             Yld1,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERR_W-1:0] ErrCount,
  output logic [2:0]       FailVec,
  output logic             FailValid
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [2:0]       vec_idx, vec_nx, vec_inc;
  logic [2:0]       abc_nx;
  logic [ERR_W-1:0] err_nx;
  logic [2:0]       fvec_nx;
  logic             fvalid_nx, pass_nx;
  logic             tmr_load, tmr_tick, tmr_zero;
  logic             expect_y, mismatch;

  assign vec_inc  = vec_idx + 3'd1;
  assign expect_y = TruthTable[{C, B, A}];
  assign mismatch = (Y != expect_y) || (Yld0 != expect_y) || (Yld1 != expect_y);

  cts_settle_timer u_timer (
    .Clock    (Clock),
    .nReset   (nReset),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .tick     (tmr_tick),
    .zero     (tmr_zero)
  );

  // Next-state and next-output logic; Abort outranks both Start and advance.
  always_comb begin
    state_nx  = state;
    vec_nx    = vec_idx;
    abc_nx    = {C, B, A};
    err_nx    = ErrCount;
    fvec_nx   = FailVec;
    fvalid_nx = FailValid;
    pass_nx   = Pass;
    tmr_load  = 1'b0;
    tmr_tick  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_nx  = ST_SETTLE;
          vec_nx    = 3'd0;
          abc_nx    = GRAY_VEC[0];
          err_nx    = '0;
          fvalid_nx = 1'b0;
          pass_nx   = 1'b0;
          tmr_load  = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (Abort) begin
          state_nx = ST_IDLE;
          abc_nx   = 3'b000;
          pass_nx  = 1'b0;
        end else if (tmr_zero) begin
          state_nx = ST_SAMPLE;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (Abort) begin
          state_nx = ST_IDLE;
          abc_nx   = 3'b000;
          pass_nx  = 1'b0;
        end else begin
          if (mismatch) begin
            err_nx = (ErrCount == ERR_MAX) ? ErrCount : (ErrCount + ERR_ONE);
            if (!FailValid) begin
              fvec_nx   = {C, B, A};
              fvalid_nx = 1'b1;
            end else begin
              fvec_nx = FailVec;
            end
          end else begin
            err_nx = ErrCount;
          end
          if (vec_idx == 3'd7) begin
            state_nx = ST_DONE;
            abc_nx   = 3'b000;
            pass_nx  = (err_nx == '0);
          end else begin
            state_nx = ST_SETTLE;
            vec_nx   = vec_inc;
            abc_nx   = GRAY_VEC[vec_inc];
            tmr_load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        abc_nx   = 3'b000;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= ST_IDLE;
      vec_idx   <= 3'd0;
      {C, B, A} <= 3'b000;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Pass      <= 1'b0;
      ErrCount  <= '0;
      FailVec   <= 3'b000;
      FailValid <= 1'b0;
    end else begin
      state     <= state_nx;
      vec_idx   <= vec_nx;
      {C, B, A} <= abc_nx;
      Busy      <= (state_nx == ST_SETTLE) || (state_nx == ST_SAMPLE);
      Done      <= (state_nx == ST_DONE);
      Pass      <= pass_nx;
      ErrCount  <= err_nx;
      FailVec   <= fvec_nx;
      FailValid <= fvalid_nx;
    end
  end

endmodule

// File: tb/tb_cell_test_seq.sv
// Directed, table-driven bench for cell_test_seq using a behavioural NAND3 cell.
module tb_cell_test_seq;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       start, abort;
  logic [7:0] tt;
  logic       a, b, c, busy, done, pass, fvalid;
  logic [3:0] err;
  logic [2:0] fvec;
  int         fault;
  logic       ideal, y, yld0, yld1;

  logic       start1;
  logic       a1, b1, c1, busy1, done1, pass1, fvalid1, y1;
  logic [3:0] err1;
  logic [2:0] fvec1;

  int errors = 0;
  int checks = 0;
  logic [2:0] gray_tb [8];

  always #5 clk = ~clk;

  // Cell model: fault 1 = Y stuck at 1, fault 2 = Yld1 stuck at 0.
  assign ideal = ~(a & b & c);
  assign y     = (fault == 1) ? 1'b1 : ideal;
  assign yld0  = ideal;
  assign yld1  = (fault == 2) ? 1'b0 : ideal;
  assign y1    = ~(a1 & b1 & c1);

  cell_test_seq dut (
    .Clock(clk), .nReset(n_reset), .Start(start), .Abort(abort), .TruthTable(tt),
    .Y(y), .Yld0(yld0), .Yld1(yld1), .A(a), .B(b), .C(c), .Busy(busy), .Done(done),
    .Pass(pass), .ErrCount(err), .FailVec(fvec), .FailValid(fvalid)
  );

  cell_test_seq #(.SETTLE_CYCLES(1)) dut1 (
    .Clock(clk), .nReset(n_reset), .Start(start1), .Abort(1'b0), .TruthTable(8'h7F),
    .Y(y1), .Yld0(y1), .Yld1(y1), .A(a1), .B(b1), .C(c1), .Busy(busy1), .Done(done1),
    .Pass(pass1), .ErrCount(err1), .FailVec(fvec1), .FailValid(fvalid1)
  );

  typedef struct {
    string      name;
    int         fault;
    logic [7:0] tt;
    int         exp_err;
    logic [2:0] exp_fvec;
    logic       exp_fvalid;
    logic       exp_pass;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_one(input vec_t v);
    int done_at;
    fault   = v.fault;
    tt      = v.tt;
    done_at = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 60 && done_at == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k <= 40) chk({v.name, " gray"}, {c, b, a}, gray_tb[(k - 1) / 5]);
      if (done) begin
        done_at = k;
        chk({v.name, " abc_at_done"}, {c, b, a}, 0);
      end
    end
    chk({v.name, " latency"}, done_at, 41);
    @(negedge clk);
    chk({v.name, " done_width"}, done, 0);
    chk({v.name, " busy"}, busy, 0);
    chk({v.name, " err"}, err, v.exp_err);
    chk({v.name, " fvalid"}, fvalid, v.exp_fvalid);
    if (v.exp_fvalid) chk({v.name, " fvec"}, fvec, v.exp_fvec);
    chk({v.name, " pass"}, pass, v.exp_pass);
  endtask

  initial begin
    int dones, first_done, second_done;
    gray_tb = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    tbl[0] = '{"ideal",    0, 8'h7F, 0, 3'd0, 1'b0, 1'b1};
    tbl[1] = '{"y_stuck1", 1, 8'h7F, 1, 3'd7, 1'b1, 1'b0};
    tbl[2] = '{"yld1_sa0", 2, 8'h7F, 7, 3'd0, 1'b1, 1'b0};
    tbl[3] = '{"tt_ff",    0, 8'hFF, 1, 3'd7, 1'b1, 1'b0};
    tbl[4] = '{"tt_00",    0, 8'h00, 7, 3'd0, 1'b1, 1'b0};

    n_reset = 1'b0; start = 1'b0; abort = 1'b0; tt = 8'h7F; fault = 0; start1 = 1'b0;
    #3;
    chk("rst abc", {c, b, a}, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
    chk("rst err", err, 0);
    chk("rst fvalid", fvalid, 0);
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_autostart busy", busy, 0);

    for (int i = 0; i < 5; i++) run_one(tbl[i]);

    // Abort in vector 1's SAMPLE cycle: its comparison must be dropped.
    fault = 0; tt = 8'h00;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    chk("abort abc", {c, b, a}, 0);
    chk("abort busy", busy, 0);
    chk("abort pass", pass, 0);
    chk("abort err", err, 1);
    chk("abort fvalid", fvalid, 1);
    chk("abort fvec", fvec, 0);
    dones = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort no_done", dones, 0);
    run_one(tbl[0]);

    // Asynchronous reset in the middle of vector 2's settle interval.
    fault = 0; tt = 8'hFD;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst abc", {c, b, a}, 3);
    chk("pre_rst err", err, 1);
    chk("pre_rst fvec", fvec, 1);
    #2 n_reset = 1'b0;
    #1;
    chk("async_rst abc", {c, b, a}, 0);
    chk("async_rst busy", busy, 0);
    chk("async_rst err", err, 0);
    chk("async_rst fvec", fvec, 0);
    chk("async_rst fvalid", fvalid, 0);
    chk("async_rst pass", pass, 0);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst busy", busy, 0);

    // SETTLE_CYCLES=1 instance with Start held high across two runs.
    @(negedge clk);
    start1 = 1'b1;
    first_done = 0; second_done = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done1 && first_done == 0) first_done = k;
      else if (done1 && second_done == 0) second_done = k;
      if (k == 18) begin
        chk("s1 idle_busy", busy1, 0);
        chk("s1 pass", pass1, 1);
      end
      if (k == 19) chk("s1 rerun_busy", busy1, 1);
    end
    start1 = 1'b0;
    chk("s1 first_done", first_done, 17);
    chk("s1 second_done", second_done, 35);
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cell_test_seq.md
CELL_TEST_SEQ -- requirements
Module: cell_test_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports Clock and nReset, listed first.
REQ-002 Parameter SETTLE_CYCLES, default 4, SHALL set the settle cycles per vector; legal range 1..255.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 nReset  input  1  asynchronous active-low reset.
REQ-005 Start  input  1  begins a test run when sampled high in IDLE.
REQ-006 Abort  input  1  cancels a run in progress.
REQ-007 TruthTable  input  8  expected Y per vector; bit index = {C,B,A}; NAND3 = 8'h7F.
REQ-008 Y, Yld0, Yld1  input  1 each  outputs of the cell under test.
REQ-009 A, B, C  output  1 each  drive to the cell under test.
REQ-010 Busy  output  1  high in SETTLE or SAMPLE.
REQ-011 Done  output  1  one-cycle pulse at run completion.
REQ-012 Pass  output  1  high when the last completed run had ErrCount == 0.
REQ-013 ErrCount  output  4  failing vectors in the current or last run; saturates at 15.
REQ-014 FailVec  output  3  {C,B,A} of the first failing vector; FailValid  output  1  marks FailVec as valid.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 Vector order SHALL be Gray code {C,B,A}: 000,001,011,010,110,111,101,100; only one input changes per step.
REQ-017 IDLE with Start=1 SHALL move to SETTLE at the next edge; at that edge it SHALL:
  - drive vector 0;
  - load the settle counter with SETTLE_CYCLES-1;
  - clear ErrCount, FailValid and Pass.
REQ-018 SETTLE SHALL decrement the counter each cycle and go to SAMPLE on the cycle the counter equals 0.
REQ-019 SAMPLE SHALL last one cycle; a vector fails if any of Y, Yld0 or Yld1 differs from TruthTable[{C,B,A}].
REQ-020 A failing vector SHALL increment ErrCount by exactly 1 (saturating at 15); the first failure SHALL load FailVec and set FailValid.
REQ-021 From SAMPLE, the FSM SHALL advance to the next vector and re-enter SETTLE (counter reloaded), or go to DONE after vector 7.
REQ-022 DONE SHALL:
  - last one cycle with Done=1;
  - update Pass;
  - return A,B,C to 000;
  - go to IDLE.
REQ-023 Start-to-Done latency SHALL be 8*(SETTLE_CYCLES+1)+1 cycles (41 at the default); Done is high in that cycle.
REQ-024 Start SHALL be ignored outside IDLE; a Start held high through DONE SHALL begin a new run from IDLE on the following cycle.
REQ-025 Abort=1 in SETTLE or SAMPLE SHALL, at the next edge:
  - go to IDLE;
  - drive A,B,C=000;
  - suppress Done and suppress the SAMPLE comparison in that cycle;
  - set Pass=0, leaving ErrCount and FailVec frozen.
REQ-026 Abort SHALL take priority over Start and over sequence advance; Abort in IDLE or DONE SHALL have no effect.
REQ-027 TruthTable SHALL be sampled only in SAMPLE; software keeps it stable during a run.
REQ-028 ErrCount, FailVec, FailValid and Pass SHALL hold their values in IDLE until the next Start.

Reset
REQ-029 nReset low SHALL immediately force:
  - state IDLE;
  - A=B=C=0;
  - Busy=0, Done=0, Pass=0;
  - ErrCount=0, FailVec=000, FailValid=0;
  - settle counter=0.
REQ-030 Reset deassertion SHALL not start a run; a Start pulse is required.

Structure
REQ-031 Shared package cell_test_pkg SHALL hold the state enum, the 8-entry Gray vector constant and ERR_W=4.
REQ-032 The settle countdown SHALL be one sub-module, cts_settle_timer (load, tick, zero flag); the rest is flat.

Verification
REQ-033 Ideal NAND3 model, TruthTable=8'h7F, Start pulse -> Done at cycle 41, ErrCount=0, Pass=1, A/B/C follow the Gray order.
REQ-034 Y stuck at 1 -> only vector 111 fails; ErrCount=1, FailVec=111, FailValid=1, Pass=0.
REQ-035 Yld1 stuck at 0 -> 7 failures; ErrCount=7, FailVec=000 (first vector).
REQ-036 Abort asserted at cycle 10 -> IDLE and A/B/C=000 next cycle, no Done, Pass=0; a new Start then completes normally.
REQ-037 nReset pulsed low mid-SETTLE -> all outputs at reset values immediately, asynchronous to Clock.
REQ-038 SETTLE_CYCLES=1 with Start held high -> Done at cycle 17, then a second run starts without a new edge.
